// File: rtl/pc_sequencer_pkg.sv
// Shared widths, stack depth and FSM state type for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int PC_W        = 9;
  localparam int IDX_W       = 4;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO return-address stack with occupancy count 0..DEPTH and a synchronous clear.
module ret_stack #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] top_ptr;

  assign top_ptr = count - CW'(1);
  assign top     = mem[top_ptr[AW-1:0]];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // NOTE: the entry array is deliberately not reset; only the count defines
  // which entries are valid, so clearing it alone discards the contents.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem[count[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED control with jump, call/return and stall.
module pc_sequencer #(
  parameter int PC_W        = pc_sequencer_pkg::PC_W,
  parameter int IDX_W       = pc_sequencer_pkg::IDX_W,
  parameter int STACK_DEPTH = pc_sequencer_pkg::STACK_DEPTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             Branch,
  input  logic             Cond,
  input  logic             Call,
  input  logic             Ret,
  input  logic [IDX_W-1:0] Jump_idx,
  output logic [IDX_W-1:0] Lut_idx,
  input  logic [PC_W-1:0]  JP,
  output logic [PC_W-1:0]  PC,
  output logic             Done,
  output logic             Stack_err
);

  import pc_sequencer_pkg::*;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] stk_top;
  logic            stk_full;
  logic            stk_empty;
  logic            run_act;
  logic            push;
  logic            pop;
  logic            clear;

  // The external table answers in the same cycle, so the index is a straight wire.
  assign Lut_idx = Jump_idx;
  assign PC      = pc_q;
  assign pc_inc  = pc_q + PC_W'(1);

  always_comb begin
    run_act = (state == ST_RUN) && !Stall;
    push    = run_act && !Halt && !Ret && Call && !stk_full;
    pop     = run_act && !Halt && Ret && !stk_empty;
    clear   = Start && (state == ST_HALTED);
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      pc_q      <= '0;
      Done      <= 1'b0;
      Stack_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state <= ST_RUN;
            pc_q  <= '0;
          end
        end
        ST_RUN: begin
          if (!Stall) begin
            if (Halt) begin
              state <= ST_HALTED;
              Done  <= 1'b1;
            end else if (Ret) begin
              if (stk_empty) begin
                pc_q      <= pc_inc;
                Stack_err <= 1'b1;
              end else begin
                pc_q <= stk_top;
              end
            end else if (Call) begin
              if (stk_full) begin
                pc_q      <= pc_inc;
                Stack_err <= 1'b1;
              end else begin
                pc_q <= JP;
              end
            end else if (Branch && Cond) begin
              pc_q <= JP;
            end else begin
              pc_q <= pc_inc;
            end
          end
        end
        ST_HALTED: begin
          if (Start) begin
            state     <= ST_RUN;
            pc_q      <= '0;
            Done      <= 1'b0;
            Stack_err <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed PC sequences.
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start, Stall, Halt, Branch, Cond, Call, Ret;
  logic [3:0] Jump_idx;
  logic [3:0] Lut_idx;
  logic [8:0] JP;
  logic [8:0] PC;
  logic       Done;
  logic       Stack_err;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Stall     (Stall),
    .Halt      (Halt),
    .Branch    (Branch),
    .Cond      (Cond),
    .Call      (Call),
    .Ret       (Ret),
    .Jump_idx  (Jump_idx),
    .Lut_idx   (Lut_idx),
    .JP        (JP),
    .PC        (PC),
    .Done      (Done),
    .Stack_err (Stack_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    Start = 0; Stall = 0; Halt = 0; Branch = 0; Cond = 0; Call = 0; Ret = 0;
    JP = '0;
  endtask

  // One clock edge, then settle before the caller samples and re-drives.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic jump_to(input int target);
    Branch = 1; Cond = 1; JP = 9'(target);
    step();
    idle_inputs();
    check($sformatf("jump_to_%0d", target), PC, target);
  endtask

  task automatic do_call(input int target, input int exp_pc, input int exp_err);
    Call = 1; JP = 9'(target);
    step();
    idle_inputs();
    check($sformatf("call_pc_%0d", exp_pc), PC, exp_pc);
    check($sformatf("call_err_%0d", exp_pc), Stack_err, exp_err);
  endtask

  task automatic do_ret(input int exp_pc, input int exp_err);
    Ret = 1;
    step();
    idle_inputs();
    check($sformatf("ret_pc_%0d", exp_pc), PC, exp_pc);
    check($sformatf("ret_err_%0d", exp_pc), Stack_err, exp_err);
  endtask

  initial begin
    idle_inputs();
    Jump_idx = 4'd0;
    Reset_n  = 1'b0;
    #12;
    check("reset_pc", PC, 0);
    check("reset_done", Done, 0);
    check("reset_err", Stack_err, 0);

    Jump_idx = 4'hA; #1;
    check("lut_idx_a", Lut_idx, 10);
    Jump_idx = 4'h5; #1;
    check("lut_idx_5", Lut_idx, 5);

    Reset_n = 1'b1;
    // IDLE ignores everything except Start.
    Branch = 1; Cond = 1; JP = 9'd77; Call = 1;
    step(); step();
    idle_inputs();
    check("idle_hold_pc", PC, 0);

    Start = 1;
    step();
    Start = 0;
    check("start_pc0", PC, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("seq_pc_%0d", i), PC, i);
      check($sformatf("seq_done_%0d", i), Done, 0);
    end

    // Start in RUN is ignored.
    Start = 1;
    step();
    Start = 0;
    check("start_in_run", PC, 6);

    // Stall holds PC even with a Call pending.
    Stall = 1; Call = 1; JP = 9'd200;
    step();
    idle_inputs();
    check("stall_pc", PC, 6);

    for (int i = 7; i <= 10; i++) step();
    check("reach_10", PC, 10);
    Branch = 1; Cond = 1; JP = 9'd53;
    step();
    idle_inputs();
    check("branch_taken", PC, 53);
    jump_to(10);
    Branch = 1; Cond = 0; JP = 9'd53;
    step();
    idle_inputs();
    check("branch_not_taken", PC, 11);

    jump_to(20);
    do_call(112, 112, 0);
    for (int i = 113; i <= 115; i++) begin
      step();
      check($sformatf("sub_pc_%0d", i), PC, i);
    end
    do_ret(21, 0);

    // Nest to full depth, overflow, then unwind and underflow.
    do_call(100, 100, 0);
    do_call(200, 200, 0);
    do_call(300, 300, 0);
    do_call(400, 400, 0);
    do_call(450, 401, 1);
    do_ret(301, 1);
    do_ret(201, 1);
    do_ret(101, 1);
    do_ret(22, 1);
    do_ret(23, 1);

    // One live entry so a stray push on Halt would be visible.
    do_call(7, 7, 1);
    Halt = 1; Call = 1; JP = 9'd50;
    step();
    idle_inputs();
    check("halt_pc", PC, 7);
    check("halt_done", Done, 1);
    check("halt_stack_cnt", int'(dut.u_stack.count), 1);
    step(); step();
    check("halted_hold_pc", PC, 7);
    check("halted_err_sticky", Stack_err, 1);

    Start = 1;
    step();
    Start = 0;
    check("restart_pc", PC, 0);
    check("restart_err", Stack_err, 0);
    check("restart_done", Done, 0);
    check("restart_stack_cnt", int'(dut.u_stack.count), 0);

    jump_to(511);
    step();
    check("wrap_pc", PC, 0);
    check("wrap_err", Stack_err, 0);
    jump_to(510);
    do_call(300, 300, 0);
    check("wrap_push_cnt", int'(dut.u_stack.count), 1);
    do_ret(511, 0);
    jump_to(511);
    do_call(300, 300, 0);
    check("wrap_push_top", int'(dut.u_stack.top), 0);

    // Asynchronous reset mid-cycle with a pop pending.
    Ret = 1;
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_pc", PC, 0);
    check("async_rst_done", Done, 0);
    check("async_rst_stack_cnt", int'(dut.u_stack.count), 0);
    idle_inputs();
    step();
    Reset_n = 1'b1;
    Branch = 1; Cond = 1; JP = 9'd99;
    step(); step();
    idle_inputs();
    check("post_rst_idle_pc", PC, 0);
    check("post_rst_err", Stack_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 9, program counter width, which matches the jump-target table output.
REQ-002 Parameter IDX_W, default 4, jump-table index width.
REQ-003 Parameter STACK_DEPTH, default 4, number of return-address stack entries.
REQ-004 Port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port Reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port Start, input, 1, a one-cycle pulse that begins program execution.
REQ-007 Port Stall, input, 1, which freezes the PC, stack and state for this cycle.
REQ-008 Port Halt, input, 1, the decoded halt instruction.
REQ-009 Port Branch, input, 1, the decoded conditional jump.
REQ-010 Port Cond, input, 1, the branch condition flag.
REQ-011 Port Call, input, 1, the decoded call.
REQ-012 Port Ret, input, 1, the decoded return.
REQ-013 Port Jump_idx, input, IDX_W, the jump-table index from the instruction.
REQ-014 Port Lut_idx, output, IDX_W, the index presented to the jump-target table.
REQ-015 Port JP, input, PC_W, the absolute target returned by the table in the same cycle.
REQ-016 Port PC, output, PC_W, the current fetch address.
REQ-017 Port Done, output, 1, high while in state HALTED.
REQ-018 Port Stack_err, output, 1, a sticky flag for stack overflow or underflow.

Function
REQ-019 Lut_idx SHALL equal Jump_idx combinationally, so JP is valid in the same cycle.
REQ-020 The block SHALL have three states: IDLE, RUN and HALTED.
REQ-021 In IDLE, Start SHALL cause a transition to RUN with PC=0; all other inputs are ignored.
REQ-022 In RUN with Stall=1, all registers SHALL hold, and Stall has top priority.
REQ-023 In RUN, control inputs SHALL be resolved with priority Halt > Ret > Call > Branch > sequential.
REQ-024 Halt SHALL hold PC and cause a transition to HALTED.
REQ-025 Ret with a non-empty stack SHALL pop the top entry into PC.
REQ-026 Ret with an empty stack SHALL set PC=PC+1 and set Stack_err.
REQ-027 Call with a non-full stack SHALL push PC+1 and load PC=JP.
REQ-028 Call with a full stack SHALL not push, SHALL set PC=PC+1 and SHALL set Stack_err.
REQ-029 Branch with Cond=1 SHALL load PC=JP; Branch with Cond=0 SHALL set PC=PC+1.
REQ-030 Sequential operation SHALL set PC=PC+1 modulo 2^PC_W, so 511 wraps to 0 without error.
REQ-031 Pushed values SHALL also wrap modulo 2^PC_W.
REQ-032 In RUN, Start SHALL be ignored.
REQ-033 In HALTED, Done SHALL be 1 and PC SHALL hold.
REQ-034 In HALTED, Start SHALL cause a transition to RUN with PC=0, stack empty and Stack_err cleared.
REQ-035 Stack_err SHALL stay set until reset or a restart from HALTED.
REQ-036 The stack SHALL be LIFO with an occupancy count from 0 to STACK_DEPTH.

Reset
REQ-037 Asserting Reset_n low SHALL immediately force state IDLE, PC=0, stack count 0, Done=0 and Stack_err=0, independent of Clk.
REQ-038 Reset asserted mid-RUN SHALL discard all stack contents, and no pending push or pop SHALL take effect.
REQ-039 After Reset_n deasserts, the block SHALL wait in IDLE for Start.

Structure
REQ-040 A shared package SHALL hold PC_W, IDX_W, STACK_DEPTH and the state enum type.
REQ-041 The return-address stack SHALL be a sub-module named ret_stack, with push, pop, data-in, top-out, full and empty ports.
REQ-042 The jump-target table SHALL stay external and connect through Lut_idx and JP.

Verification
REQ-043 Reset, then a Start pulse, then 5 free-running cycles -> PC SHALL read 0,1,2,3,4,5 and Done SHALL be 0.
REQ-044 At PC=10, Branch=1, Cond=1, with JP=53 -> next PC SHALL be 53; repeat with Cond=0 -> next PC SHALL be 11.
REQ-045 At PC=20, Call with JP=112, then 3 cycles, then Ret -> PC SHALL go 112,113,114,115, then 21.
REQ-046 Five nested Calls (depth 4) -> the fifth Call SHALL set PC=PC+1 and Stack_err=1; five Rets -> four SHALL return correctly, and the fifth SHALL set PC=PC+1 with Stack_err still 1.
REQ-047 Halt and Call asserted together at PC=7 -> PC SHALL hold at 7, Done SHALL be 1 and the stack SHALL be unchanged.
REQ-048 Start pulse in HALTED -> PC SHALL be 0 and Stack_err SHALL be 0; then Reset_n low mid-RUN at PC=300 -> PC SHALL become 0 immediately, in state IDLE.
